rcb_alloc: RTL and testbench



---
 rtl/rcb_pkg.sv | 18 +
 rtl/rr_arb.sv | 44 ++++
 rtl/rcb_alloc.sv | 116 +++++++++++
 tb/tb_rcb_alloc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcb_pkg.sv
// ----------------------------------------------------------------------------
// rcb_pkg
// Shared definitions for the wormhole switch allocator.
//   NN_DEF        : default number of input ports
//   MN_DEF        : default number of output ports
//   alloc_state_t : per-output allocator state (IDLE / LOCKED)
// ----------------------------------------------------------------------------
package rcb_pkg;

    localparam int NN_DEF = 5;
    localparam int MN_DEF = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/rr_arb.sv
// ----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter. Searches the request vector starting at
// the pointer position and wrapping from N-1 back to 0; the first set bit wins.
//   i_req : request vector, one bit per requester
//   i_ptr : index of the highest-priority requester this cycle
//   i_en  : arbitration enable; when low no grant is issued
//   o_gnt : one-hot grant (zero when disabled or nothing requests)
//   o_idx : binary index of the granted requester (0 when no grant)
// ----------------------------------------------------------------------------
import rcb_pkg::*;

module rr_arb #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);

    logic          w_found;
    logic [PW-1:0] w_pos;

    // Walk the requesters in priority order (ptr, ptr+1, ... wrapping) and
    // latch onto the first one that is asking.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = PW'((int'(i_ptr) + off) % N);
            if (i_en && !w_found && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcb_alloc.sv
// ----------------------------------------------------------------------------
// rcb_alloc
// Wormhole switch allocator feeding the request crossbar. Each output port is
// owned by a single input from header to tail; a round-robin arbiter per
// output picks the next owner when the port is free.
//   clk         : router clock
//   rst         : asynchronous active-high reset
//   i_req_vld   : [NN]    input k has a flit waiting for an output
//   i_req_dst   : [NN*MN] one-hot requested output of input k at [k*MN +: MN]
//   i_req_tail  : [NN]    pending flit of input k is a tail flit
//   i_flit_fire : [NN]    flit of input k crossed the crossbar this cycle
//   o_cfg       : [MN*NN] crossbar configuration, row i at [i*NN +: NN];
//                 bit k of row i connects input k to output i
//   o_gnt       : [NN]    input k currently owns some output
// ----------------------------------------------------------------------------
import rcb_pkg::*;

module rcb_alloc #(
    parameter int NN = NN_DEF,
    parameter int MN = MN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NN-1:0]     i_req_vld,
    input  logic [NN*MN-1:0]  i_req_dst,
    input  logic [NN-1:0]     i_req_tail,
    input  logic [NN-1:0]     i_flit_fire,
    output logic [MN*NN-1:0]  o_cfg,
    output logic [NN-1:0]     o_gnt
);

    localparam int PW = (NN > 1) ? $clog2(NN) : 1;

    logic [NN-1:0] w_cfgRow [MN];

    for (genvar gi = 0; gi < MN; gi++) begin : gOut

        alloc_state_t  r_state;
        logic [PW-1:0] r_ptr;
        logic [PW-1:0] r_owner;
        logic [NN-1:0] r_cfg;

        logic [NN-1:0] w_req;
        logic [NN-1:0] w_arbGnt;
        logic [PW-1:0] w_arbIdx;
        logic          w_arbEn;
        logic          w_release;

        // Requesters for this output: valid inputs whose destination bit
        // points here.
        for (genvar gk = 0; gk < NN; gk++) begin : gReq
            assign w_req[gk] = i_req_vld[gk] & i_req_dst[gk*MN + gi];
        end

        // Arbitration only runs while the port is free, so the release cycle
        // itself never re-grants and one idle cycle always separates tenures.
        assign w_arbEn   = (r_state == IDLE);
        assign w_release = i_flit_fire[r_owner] & i_req_tail[r_owner];

        rr_arb #(
            .N  (NN),
            .PW (PW)
        ) uArb (
            .i_req (w_req),
            .i_ptr (r_ptr),
            .i_en  (w_arbEn),
            .o_gnt (w_arbGnt),
            .o_idx (w_arbIdx)
        );

        // Per-output ownership FSM. The owner keeps the port through bubbles
        // (req_vld low) and only gives it up when its tail flit fires.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= IDLE;
                r_ptr   <= '0;
                r_owner <= '0;
                r_cfg   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (|w_arbGnt) begin
                            r_cfg   <= w_arbGnt;
                            r_owner <= w_arbIdx;
                            r_ptr   <= (w_arbIdx == PW'(NN - 1)) ? '0 : w_arbIdx + 1'b1;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (w_release) begin
                            r_cfg   <= '0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_cfg   <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end

        assign w_cfgRow[gi]         = r_cfg;
        assign o_cfg[gi*NN +: NN]   = r_cfg;

    end

    // An input holds a grant when any output row selects it.
    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < MN; i++) begin
            o_gnt = o_gnt | w_cfgRow[i];
        end
    end

endmodule

// File: tb/tb_rcb_alloc.sv
// ----------------------------------------------------------------------------
// tb_rcb_alloc
// Directed self-checking bench for the wormhole switch allocator.
// ----------------------------------------------------------------------------
module tb_rcb_alloc;

    localparam int NN = 5;
    localparam int MN = 5;

    logic              clk;
    logic              rst;
    logic [NN-1:0]     vld;
    logic [NN*MN-1:0]  dst;
    logic [NN-1:0]     tail;
    logic [NN-1:0]     fire;
    logic [MN*NN-1:0]  cfg;
    logic [NN-1:0]     gnt;

    int checks = 0;
    int errors = 0;

    int cnt [NN];
    int grants;
    int budget;
    int prevWin;
    int rotErr;
    int win;
    logic [NN-1:0] row;
    logic [NN*MN-1:0] rdst;

    rcb_alloc #(
        .NN (NN),
        .MN (MN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_vld   (vld),
        .i_req_dst   (dst),
        .i_req_tail  (tail),
        .i_flit_fire (fire),
        .o_cfg       (cfg),
        .o_gnt       (gnt)
    );

    // Free-running router clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NN-1:0] cfgRow(input int i);
        cfgRow = cfg[i*NN +: NN];
    endfunction

    function automatic logic [NN*MN-1:0] dstFor(input int k, input int o);
        logic [NN*MN-1:0] v;
        v = '0;
        v[k*MN + o] = 1'b1;
        return v;
    endfunction

    function automatic int oneIdx(input logic [NN-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NN; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NN-1:0] v, input logic [NN*MN-1:0] d,
                                 input logic [NN-1:0] t, input logic [NN-1:0] f);
        vld  = v;
        dst  = d;
        tail = t;
        fire = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Structural invariants sampled mid-cycle: every row one-hot or zero,
    // every column at most one bit, gnt equal to the OR of all rows.
    always @(negedge clk) begin
        logic ok;
        logic [NN-1:0] col;
        logic [NN-1:0] orRows;
        ok     = 1'b1;
        orRows = '0;
        for (int i = 0; i < MN; i++) begin
            if (!$onehot0(cfgRow(i))) ok = 1'b0;
            orRows = orRows | cfgRow(i);
        end
        for (int k = 0; k < NN; k++) begin
            for (int i = 0; i < MN; i++) col[i] = cfg[i*NN + k];
            if (!$onehot0(col)) ok = 1'b0;
        end
        if (orRows !== gnt) ok = 1'b0;
        checkOutput("invariants", {31'd0, ok}, 32'd1);
    end

    // Flag illegal multi-hot or empty destinations on any valid request.
    always @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (vld[k] === 1'b1) begin
                assert ($onehot(dst[k*MN +: MN])) else begin
                    errors++;
                    $error("[TB] FAIL illegal_dst: input %0d dst %b", k, dst[k*MN +: MN]);
                end
            end
        end
    end

    // Linear directed sequence covering reset, single packet, contention,
    // parallel grants, ownership hold, fairness and asynchronous reset.
    initial begin
        applyStimulus('0, '0, '0, '0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_cfg", cfg, 0);
        checkOutput("reset_gnt", gnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single 5-flit packet from input 2 to output 3.
        applyStimulus(5'b00100, dstFor(2, 3), 5'b00000, 5'b00000);
        tick();
        checkOutput("single_cfg3", cfgRow(3), 5'b00100);
        checkOutput("single_gnt", gnt, 5'b00100);
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(5'b00100, dstFor(2, 3), 5'b00000, 5'b00100);
            tick();
            checkOutput($sformatf("single_hold_%0d", f), cfgRow(3), 5'b00100);
        end
        applyStimulus(5'b00100, dstFor(2, 3), 5'b00100, 5'b00100);
        tick();
        checkOutput("single_release", cfgRow(3), 5'b00000);
        checkOutput("single_gnt_off", gnt, 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();

        // Inputs 0, 1, 4 contend for output 1 with single-flit packets.
        rdst = dstFor(0, 1) | dstFor(1, 1) | dstFor(4, 1);
        applyStimulus(5'b10011, rdst, 5'b10011, 5'b00000);
        tick();
        checkOutput("cont_first", cfgRow(1), 5'b00001);
        applyStimulus(5'b10011, rdst, 5'b10011, 5'b00001);
        tick();
        checkOutput("cont_idle1", cfgRow(1), 5'b00000);
        applyStimulus(5'b10010, rdst, 5'b10010, 5'b00000);
        tick();
        checkOutput("cont_second", cfgRow(1), 5'b00010);
        applyStimulus(5'b10010, rdst, 5'b10010, 5'b00010);
        tick();
        checkOutput("cont_idle2", cfgRow(1), 5'b00000);
        applyStimulus(5'b10000, rdst, 5'b10000, 5'b00000);
        tick();
        checkOutput("cont_third", cfgRow(1), 5'b10000);
        applyStimulus(5'b10000, rdst, 5'b10000, 5'b10000);
        tick();
        checkOutput("cont_idle3", cfgRow(1), 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();
        // Pointer wrapped to 0: with inputs 0 and 4 asking, input 0 wins.
        rdst = dstFor(0, 1) | dstFor(4, 1);
        applyStimulus(5'b10001, rdst, 5'b10001, 5'b00000);
        tick();
        checkOutput("cont_ptr_wrap", cfgRow(1), 5'b00001);
        applyStimulus(5'b00001, rdst, 5'b00001, 5'b00001);
        tick();
        checkOutput("cont_wrap_release", cfgRow(1), 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();

        // Input 0 -> output 2 and input 1 -> output 3 on the same edge.
        rdst = dstFor(0, 2) | dstFor(1, 3);
        applyStimulus(5'b00011, rdst, 5'b00000, 5'b00000);
        tick();
        checkOutput("par_cfg2", cfgRow(2), 5'b00001);
        checkOutput("par_cfg3", cfgRow(3), 5'b00010);
        checkOutput("par_gnt", gnt, 5'b00011);
        applyStimulus(5'b00011, rdst, 5'b00011, 5'b00011);
        tick();
        checkOutput("par_release", gnt, 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();

        // Input 0 owns output 4, bubbles for 3 cycles while input 3 waits.
        rdst = dstFor(0, 4) | dstFor(3, 4);
        applyStimulus(5'b01001, rdst, 5'b00000, 5'b00000);
        tick();
        checkOutput("hold_grant", cfgRow(4), 5'b00001);
        applyStimulus(5'b01001, rdst, 5'b00000, 5'b00001);
        tick();
        checkOutput("hold_flit1", cfgRow(4), 5'b00001);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(5'b01000, rdst, 5'b00000, 5'b00000);
            tick();
            checkOutput($sformatf("hold_bubble_%0d", b), cfgRow(4), 5'b00001);
        end
        applyStimulus(5'b01001, rdst, 5'b00001, 5'b00001);
        tick();
        checkOutput("hold_tail_release", cfgRow(4), 5'b00000);
        applyStimulus(5'b01000, rdst, 5'b00000, 5'b00000);
        tick();
        checkOutput("hold_next_owner", cfgRow(4), 5'b01000);
        applyStimulus(5'b01000, rdst, 5'b01000, 5'b01000);
        tick();
        checkOutput("hold_next_release", cfgRow(4), 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();

        // Fairness soak: everyone wants output 0, single-flit packets.
        rdst = '0;
        for (int k = 0; k < NN; k++) rdst = rdst | dstFor(k, 0);
        for (int k = 0; k < NN; k++) cnt[k] = 0;
        grants  = 0;
        budget  = 0;
        prevWin = NN - 1;
        rotErr  = 0;
        applyStimulus(5'b11111, rdst, 5'b11111, 5'b00000);
        while (grants < 100 && budget < 400) begin
            tick();
            budget++;
            row = cfgRow(0);
            if (row != '0) begin
                win = oneIdx(row);
                if (win >= 0) cnt[win]++;
                if (win != (prevWin + 1) % NN) rotErr++;
                prevWin = win;
                grants++;
                fire = row;
            end else begin
                fire = '0;
            end
        end
        checkOutput("soak_grants", grants, 100);
        checkOutput("soak_rotation", rotErr, 0);
        for (int k = 0; k < NN; k++) begin
            checkOutput($sformatf("soak_count_%0d", k),
                        {31'd0, (cnt[k] >= 19 && cnt[k] <= 21)}, 32'd1);
        end
        tick();
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("soak_idle", cfgRow(0), 5'b00000);

        // Random traffic, then asynchronous reset in the middle of a cycle.
        rdst = '0;
        for (int k = 0; k < NN; k++) rdst = rdst | dstFor(k, int'($urandom_range(0, MN - 1)));
        applyStimulus(5'b11111, rdst, 5'b00000, NN'($urandom));
        tick();
        tick();
        tick();
        checkOutput("rst_pre_busy", {31'd0, |gnt}, 32'd1);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_async_cfg", cfg, 0);
        checkOutput("rst_async_gnt", gnt, 0);
        tick();
        tick();
        checkOutput("rst_held_cfg", cfg, 0);
        rdst = '0;
        for (int k = 0; k < NN; k++) rdst = rdst | dstFor(k, 2);
        rst = 1'b0;
        applyStimulus(5'b11111, rdst, 5'b00000, 5'b00000);
        tick();
        checkOutput("rst_first_cfg2", cfgRow(2), 5'b00001);
        checkOutput("rst_first_gnt", gnt, 5'b00001);
        applyStimulus(5'b00001, rdst, 5'b00001, 5'b00001);
        tick();
        checkOutput("rst_final_release", cfgRow(2), 5'b00000);
        applyStimulus('0, '0, '0, '0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
